shift_add_mult_seq: RTL and testbench
=====================================

Name: shift_add_mult_seq

Overview:
- Upstream sequencer for the serial shift-add multiplier stage.
- Accepts operand pairs over a valid/ready handshake and drives the multiplier's parallel operand, serial operand and MULT_EN.
- Counts the N accumulate cycles, captures the 2N-bit product, and presents it downstream over a valid/ready handshake.
- Supplies the load/enable sequencing that the multiplier datapath (no reset, no done flag) lacks.

Parameters:
- N, 4, operand width; product width is 2*N; same value as the multiplier stage.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_a  input  N  multiplicand; drives the parallel operand.
- in_b  input  N  multiplier; drives the serial operand.
- mult_par  output  N  to multiplier parallel_IN.
- mult_ser  output  N  to multiplier serial_IN.
- mult_en  output  1  to multiplier MULT_EN.
- mult_product  input  2*N  from multiplier product.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts result.
- res_data  output  2*N  captured product.

Behaviour:
- Clock/reset: one clock, clk; rst_n is asynchronous, active-low. Reset forces state IDLE, count 0, a_reg/b_reg/res_data 0, res_valid 0, mult_en 0, in_ready 0 while asserted.
- Outputs: mult_par = a_reg, mult_ser = b_reg, both registered.
- Counter: cnt, width $clog2(N+1).
- FSM states: IDLE, LOAD, RUN, CAPT, HOLD.
- IDLE:
  - in_ready=1, mult_en=0, res_valid=0.
  - On in_valid&in_ready: a_reg<=in_a, b_reg<=in_b, cnt<=0, go to LOAD.
- LOAD:
  - mult_en=0 for exactly one edge; the multiplier latches a_reg/b_reg and clears product on this edge.
  - Go to RUN.
- RUN:
  - mult_en=1; cnt increments each edge.
  - Leave after N edges in RUN, i.e. when cnt==N-1 at the edge; go to CAPT.
- CAPT:
  - mult_en stays 1; the multiplier adds only zeros now, so the product is stable.
  - res_data<=mult_product, res_valid<=1, go to HOLD.
- HOLD:
  - res_valid=1, res_data stable, in_ready=0, mult_en=1.
  - On res_ready: res_valid<=0, go to IDLE.
- Latency: operand accept at edge E; res_valid rises after edge E+N+2. Throughput is one product per N+4 cycles when res_ready is tied high.
- Result width: result is the unsigned product, exactly 2*N bits; no truncation or overflow is possible.
- Boundary conditions:
  - in_valid while busy (not IDLE): ignored and held off by in_ready=0; the operands are not sampled.
  - res_ready and in_valid both high in HOLD: the result is retired; the new operands are accepted no earlier than the next cycle in IDLE.
  - res_ready high without res_valid: no effect.
  - Operand 0 on either side: the full sequence still runs; result 0.
  - Reset mid-operation (LOAD/RUN/CAPT/HOLD): immediate return to IDLE, pending result discarded, mult_en=0. The multiplier (no reset) is reloaded by the next LOAD. Its product is never sampled without a preceding LOAD.
  - cnt never wraps; it is only meaningful in RUN and reloads to 0 on accept.

Optional Feature:
- Macro: MULT_SELFCHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit, reset 0).
  - In CAPT, mult_product is compared with a_reg*b_reg computed in the sequencer (2*N-bit unsigned).
  - On mismatch, chk_err is set sticky until rst_n.
  - res_data still carries mult_product unmodified.
- Undefined: no chk_err port and no comparator logic; behaviour is otherwise identical.

Test Plan:
- Reset then single op a=13 (1101), b=11 (1011), res_ready=1 -> res_valid after N+2 edges from accept, res_data=143 (8'h8F); mult_en low exactly one cycle.
- Extremes a=15,b=15 -> 225; a=0,b=9 -> 0; a=7,b=0 -> 0; each with full-length sequence timing unchanged.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> res_data stable at 143, in_ready=0, in_valid pulses ignored; then res_ready=1 -> IDLE, next op a=5,b=6 -> 30.
- Reset mid-RUN (rst_n low at cnt=2) -> immediately IDLE, res_valid=0, mult_en=0; next op a=3,b=9 -> 27 correct.
- Streaming 20 random pairs with res_ready=1, in_valid always 1 -> each result equals a*b, one result per N+4 cycles, no drops or duplicates.
- With MULT_SELFCHECK_EN: force mult_product bit 0 flipped in CAPT for a=13,b=11 -> chk_err=1 and stays 1 until reset; unforced run keeps chk_err=0.

Source files
------------

// File: rtl/shift_add_mult_seq.sv
// ---------------------------------------------------------------------------
// shift_add_mult_seq
//
// Sequencer that sits in front of a serial shift-add multiplier datapath.
// The datapath has no reset and no done flag. This block supplies the
// load/enable sequencing that the datapath lacks:
//   - It takes an operand pair over a valid/ready handshake.
//   - It holds MULT_EN low for one edge so the datapath loads its operands
//     and clears its product.
//   - It runs N accumulate edges.
//   - It captures the 2N-bit product and offers it downstream over a
//     valid/ready handshake.
//
// Parameters
//   N             operand width. The product is 2*N bits wide.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      operand pair valid
//   in_ready      sequencer can accept an operand pair (IDLE only)
//   in_a          multiplicand, driven onto mult_par
//   in_b          multiplier, driven onto mult_ser
//   mult_par      registered parallel operand to the datapath
//   mult_ser      registered serial operand to the datapath
//   mult_en       registered MULT_EN to the datapath
//   mult_product  product returned by the datapath
//   res_valid     captured product valid
//   res_ready     downstream accepts the result
//   res_data      captured product
//   chk_err       (MULT_SELFCHECK_EN only) sticky product-mismatch flag
//
// Optional build macro
//   MULT_SELFCHECK_EN
//     Adds chk_err and a local a*b reference. In CAPT the reference is
//     compared against mult_product. res_data is never altered by the check.
// ---------------------------------------------------------------------------
module shift_add_mult_seq #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic [N-1:0]     mult_par,
    output logic [N-1:0]     mult_ser,
    output logic             mult_en,
    input  logic [2*N-1:0]   mult_product,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*N-1:0]   res_data
`ifdef MULT_SELFCHECK_EN
    ,
    output logic             chk_err
`endif
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] CAPT = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    logic [2:0]     state_r;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic           mult_en_r;
    logic           in_ready_r;
    logic           res_valid_r;
    logic [2*N-1:0] res_data_r;

`ifdef MULT_SELFCHECK_EN
    logic           chk_err_r;

    // Unsigned reference product, zero-extended to 2N bits so nothing is lost.
    function automatic logic [2*N-1:0] ref_product(input logic [N-1:0] a,
                                                   input logic [N-1:0] b);
        ref_product = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    endfunction
`endif

    // Sequencer FSM, operand registers, run counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            a_r         <= {N{1'b0}};
            b_r         <= {N{1'b0}};
            mult_en_r   <= 1'b0;
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {(2*N){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    mult_en_r   <= 1'b0;
                    res_valid_r <= 1'b0;
                    // in_ready is a register, so it comes up one cycle after reset release.
                    if (in_valid && in_ready_r) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= LOAD;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                LOAD: begin
                    // mult_en stayed low across the LOAD edge, so the datapath loads now.
                    mult_en_r <= 1'b1;
                    state_r   <= RUN;
                end
                RUN: begin
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= CAPT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                CAPT: begin
                    // The datapath only adds zeros from here on, so its product is final.
                    res_data_r  <= mult_product;
                    res_valid_r <= 1'b1;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        mult_en_r   <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= HOLD;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mult_en_r   <= 1'b0;
                    in_ready_r  <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MULT_SELFCHECK_EN
    // Sticky flag: set when the datapath product disagrees with the local reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_r <= 1'b0;
        end else if ((state_r == CAPT) && (mult_product != ref_product(a_r, b_r))) begin
            chk_err_r <= 1'b1;
        end else begin
            chk_err_r <= chk_err_r;
        end
    end

    assign chk_err = chk_err_r;
`endif

    assign in_ready  = in_ready_r;
    assign mult_par  = a_r;
    assign mult_ser  = b_r;
    assign mult_en   = mult_en_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Scoreboard testbench for shift_add_mult_seq. It includes a behavioural
// model of the serial shift-add multiplier that the sequencer drives.
module tb_shift_add_mult_seq;

    localparam int N  = 4;
    localparam int PW = 2 * N;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [N-1:0]  mult_par;
    logic [N-1:0]  mult_ser;
    logic          mult_en;
    logic [PW-1:0] mult_product;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] res_data;
`ifdef MULT_SELFCHECK_EN
    logic          chk_err;
`endif

    shift_add_mult_seq #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mult_par     (mult_par),
        .mult_ser     (mult_ser),
        .mult_en      (mult_en),
        .mult_product (mult_product),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data)
`ifdef MULT_SELFCHECK_EN
        ,
        .chk_err      (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural serial shift-add multiplier: it loads when MULT_EN is low
    // and adds the shifted multiplicand on each set serial bit when high.
    logic [PW-1:0] m_acc;
    logic [PW-1:0] m_a;
    logic [N-1:0]  m_b;
    logic          flip;

    always @(posedge clk) begin
        if (!mult_en) begin
            m_a   <= {{N{1'b0}}, mult_par};
            m_b   <= mult_ser;
            m_acc <= {PW{1'b0}};
        end else begin
            if (m_b[0]) m_acc <= m_acc + m_a;
            m_a <= m_a << 1;
            m_b <= m_b >> 1;
        end
    end

    assign mult_product = m_acc ^ {{(PW-1){1'b0}}, flip};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] data;
        int            acc;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int last_acc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one operand pair, push the expected result, and check the load/enable pattern.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [PW-1:0] exp, input bit stream);
        exp_t e;
        int   k;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            e.data = exp;
            e.acc  = cyc + 1;
            q.push_back(e);
            if (stream && last_acc >= 0) check("stream_spacing", e.acc - last_acc, N + 4);
            last_acc = e.acc;
            @(negedge clk);
            if (!stream) in_valid = 1'b0;
            check("load_mult_en_low", {31'd0, mult_en}, 32'd0);
            check("load_par", {28'd0, mult_par}, {28'd0, a});
            check("load_ser", {28'd0, mult_ser}, {28'd0, b});
            check("load_in_ready_low", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            check("run_mult_en_high", {31'd0, mult_en}, 32'd1);
        end
    endtask

    task automatic drain;
        int k;
        k = 0;
        while ((q.size() != 0 || res_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", (q.size() != 0 || res_valid) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Monitor: pop the expected value on each new result, check its latency, and check it stays stable.
    bit            seen = 1'b0;
    logic [PW-1:0] held;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = res_data;
                    if (q.size() == 0) begin
                        check("unexpected_result", {24'd0, res_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check("res_data", {24'd0, res_data}, {24'd0, e.data});
                        check("res_latency", cyc - e.acc, N + 2);
                    end
                end else begin
                    check("res_stable", {24'd0, res_data}, {24'd0, held});
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    logic [N-1:0]  sa [20] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd6, 4'd12,
                               4'd15, 4'd3, 4'd13, 4'd7, 4'd5, 4'd8, 4'd2, 4'd9, 4'd14, 4'd1};
    logic [N-1:0]  sb [20] = '{4'd1, 4'd3, 4'd4, 4'd15, 4'd7, 4'd12, 4'd13, 4'd2, 4'd9, 4'd12,
                               4'd1, 4'd5, 4'd14, 4'd7, 4'd11, 4'd8, 4'd15, 4'd10, 4'd14, 4'd15};
    logic [PW-1:0] sp [20] = '{8'd1, 8'd6, 8'd16, 8'd120, 8'd63, 8'd120, 8'd143, 8'd28, 8'd54, 8'd144,
                               8'd15, 8'd15, 8'd182, 8'd49, 8'd55, 8'd64, 8'd30, 8'd90, 8'd196, 8'd15};

    initial begin
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;
        flip      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_mult_en", {31'd0, mult_en}, 32'd0);
        check("rst_res_data", {24'd0, res_data}, 32'd0);
        check("rst_mult_par", {28'd0, mult_par}, 32'd0);
        rst_n = 1'b1;

        // Basic operation and extremes.
        do_op(4'd13, 4'd11, 8'd143, 1'b0); drain();
        do_op(4'd15, 4'd15, 8'd225, 1'b0); drain();
        do_op(4'd0,  4'd9,  8'd0,   1'b0); drain();
        do_op(4'd7,  4'd0,  8'd0,   1'b0); drain();

        // Backpressure: hold the result for 10 cycles while in_valid pulses are ignored.
        res_ready = 1'b0;
        do_op(4'd13, 4'd11, 8'd143, 1'b0);
        k = 0;
        while (!res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_a     = 4'd1;
            in_b     = 4'd1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_res_data", {24'd0, res_data}, 32'd143);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        do_op(4'd5, 4'd6, 8'd30, 1'b0); drain();

        // Reset during RUN, with cnt at 2.
        do_op(4'd9, 4'd9, 8'd81, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_mult_en", {31'd0, mult_en}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        void'(q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd3, 4'd9, 8'd27, 1'b0); drain();

        // Streaming with in_valid held high and res_ready tied high.
        last_acc = -1;
        for (int i = 0; i < 20; i++) do_op(sa[i], sb[i], sp[i], 1'b1);
        in_valid = 1'b0;
        drain();

`ifdef MULT_SELFCHECK_EN
        check("chk_err_clean", {31'd0, chk_err}, 32'd0);
        flip = 1'b1;
        do_op(4'd13, 4'd11, 8'd142, 1'b0); drain();
        flip = 1'b0;
        check("chk_err_set", {31'd0, chk_err}, 32'd1);
        do_op(4'd2, 4'd2, 8'd4, 1'b0); drain();
        check("chk_err_sticky", {31'd0, chk_err}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("chk_err_rst", {31'd0, chk_err}, 32'd0);
        rst_n = 1'b1;
        do_op(4'd13, 4'd11, 8'd143, 1'b0); drain();
        check("chk_err_unforced", {31'd0, chk_err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
